// File: rtl/raytracer_pkg.sv
// Shared definitions for the ray-tracer pixel pipeline: dispatcher FSM
// states, default sizing and the core-count clamp helper.
package raytracer_pkg;

  localparam int MAX_CORES_DEFAULT = 2;
  localparam int IDX_W_DEFAULT     = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Highest core number that takes part in the frame: the requested extra
  // cores, clamped to the cores that physically exist.
  function automatic int clamp_active(input logic [1:0] extra, input int max_cores);
    int req;
    req = int'(extra);
    return (req > max_cores - 1) ? max_cores - 1 : req;
  endfunction

endpackage

// File: rtl/pixel_dispatcher.sv
// Frame-level job dispatcher: hands pixel indices 1..width*height to the
// compute cores in strict round-robin order, then waits until every
// finished pixel has left the pixel buffer before signalling frame_done.
module pixel_dispatcher
  import raytracer_pkg::*;
#(
  parameter int MAX_CORES = MAX_CORES_DEFAULT,
  parameter int IDX_W     = IDX_W_DEFAULT
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [12:0]          image_width,
  input  logic [12:0]          image_height,
  input  logic [1:0]           no_of_extra_cores,
  input  logic [MAX_CORES-1:0] core_ready,
  output logic [MAX_CORES-1:0] core_valid,
  output logic [IDX_W-1:0]     core_loop_index,
  input  logic                 pix_out_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_error
);

  localparam int PTR_W = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;

  state_t             state;
  logic [12:0]        width_q;
  logic [12:0]        height_q;
  logic [PTR_W-1:0]   active;
  logic [PTR_W-1:0]   ptr;
  logic [IDX_W-1:0]   next_index;
  logic [IDX_W-1:0]   pix_count;
  logic [25:0]        product;
  logic [IDX_W-1:0]   total;
  logic               handshake;
  logic               last_job;

  // Frame size derived from the latched geometry, so later input changes
  // cannot disturb a frame in flight.
  assign product   = 26'(width_q) * 26'(height_q);
  assign total     = IDX_W'(product);
  assign handshake = (state == ST_DISPATCH) && core_ready[ptr];
  assign last_job  = (next_index == total);

  // Main FSM: latch configuration, step through jobs, drain, finish.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= ST_IDLE;
      width_q    <= '0;
      height_q   <= '0;
      active     <= '0;
      ptr        <= '0;
      next_index <= '0;
      cfg_error  <= 1'b0;
    end else begin
      cfg_error <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // Abort wins over any handshake in the same cycle.
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if ((image_width == '0) || (image_height == '0)) begin
                cfg_error <= 1'b1;
              end else begin
                width_q    <= image_width;
                height_q   <= image_height;
                active     <= PTR_W'(clamp_active(no_of_extra_cores, MAX_CORES));
                next_index <= IDX_W'(1);
                ptr        <= '0;
                state      <= ST_DISPATCH;
              end
            end
          end
          ST_DISPATCH: begin
            if (handshake) begin
              next_index <= next_index + IDX_W'(1);
              ptr        <= (ptr == active) ? '0 : ptr + PTR_W'(1);
              if (last_job) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (pix_count == total) state <= ST_DONE;
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Finished-pixel counter: cleared while idle, counts in every active state
  // (including the cycle of the last handshake).
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pix_count <= '0;
    end else if (state == ST_IDLE) begin
      pix_count <= '0;
    end else if (pix_out_valid) begin
      pix_count <= pix_count + IDX_W'(1);
    end
  end

  // One-hot job offer to the core under the round-robin pointer only.
  // NOTE: the default assignment at the top of always_comb guarantees every
  // path drives core_valid, so no latch is inferred.
  always_comb begin
    core_valid = '0;
    if (state == ST_DISPATCH) core_valid[ptr] = 1'b1;
  end

  assign core_loop_index = next_index;
  assign busy            = (state == ST_DISPATCH) || (state == ST_DRAIN);
  assign frame_done      = (state == ST_DONE);

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher (MAX_CORES=2, IDX_W=32).
module tb_pixel_dispatcher;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic        abort;
  logic [12:0] image_width;
  logic [12:0] image_height;
  logic [1:0]  no_of_extra_cores;
  logic [1:0]  core_ready;
  logic [1:0]  core_valid;
  logic [31:0] core_loop_index;
  logic        pix_out_valid;
  logic        busy;
  logic        frame_done;
  logic        cfg_error;

  int passed = 0;
  int total  = 0;

  pixel_dispatcher #(.MAX_CORES(2), .IDX_W(32)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .start             (start),
    .abort             (abort),
    .image_width       (image_width),
    .image_height      (image_height),
    .no_of_extra_cores (no_of_extra_cores),
    .core_ready        (core_ready),
    .core_valid        (core_valid),
    .core_loop_index   (core_loop_index),
    .pix_out_valid     (pix_out_valid),
    .busy              (busy),
    .frame_done        (frame_done),
    .cfg_error         (cfg_error)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_start(input logic [12:0] w, input logic [12:0] h, input logic [1:0] extra);
    image_width       = w;
    image_height      = h;
    no_of_extra_cores = extra;
    start             = 1'b1;
    tick();
    start             = 1'b0;
  endtask

  // Watch a bounded window and return how many frame_done pulses appeared.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      if (frame_done) pulses++;
      tick();
    end
  endtask

  initial begin
    int pulses;
    areset            = 1'b1;
    start             = 1'b0;
    abort             = 1'b0;
    image_width       = '0;
    image_height      = '0;
    no_of_extra_cores = '0;
    core_ready        = '0;
    pix_out_valid     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(core_valid), 32'h0);
    check("rst_index", core_loop_index, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    check("rst_cfgerr", 32'(cfg_error), 32'h0);
    areset = 1'b0;
    tick();

    // 4x2 frame, two cores always ready; config inputs change after latch
    // and a stray start mid-frame must be ignored.
    core_ready = 2'b11;
    run_start(13'd4, 13'd2, 2'd1);
    image_width  = 13'd0;
    image_height = 13'd7;
    check("f1_busy", 32'(busy), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("f1_valid_%0d", i), 32'(core_valid), (i % 2 == 1) ? 32'h1 : 32'h2);
      check($sformatf("f1_index_%0d", i), core_loop_index, 32'(i));
      start = (i == 3);
      tick();
    end
    start = 1'b0;
    check("f1_drain_valid", 32'(core_valid), 32'h0);
    check("f1_drain_busy", 32'(busy), 32'h1);
    pix_out_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("f1_no_early_done", 32'(frame_done), 32'h0);
    tick();
    pix_out_valid = 1'b0;
    count_done(6, pulses);
    check("f1_done_pulses", 32'(pulses), 32'h1);
    check("f1_idle_busy", 32'(busy), 32'h0);

    // Core 1 stalls holding index 2; core 0 must not get index 3.
    core_ready = 2'b01;
    run_start(13'd4, 13'd2, 2'd1);
    check("st_idx1", core_loop_index, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("st_hold_valid_%0d", i), 32'(core_valid), 32'h2);
      check($sformatf("st_hold_index_%0d", i), core_loop_index, 32'd2);
      tick();
    end
    core_ready = 2'b11;
    tick();
    check("st_idx3_valid", 32'(core_valid), 32'h1);
    check("st_idx3_index", core_loop_index, 32'd3);

    // Abort right after index 3 is accepted, coinciding with index 4's handshake.
    tick();
    check("ab_idx4_index", core_loop_index, 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_valid", 32'(core_valid), 32'h0);
    pix_out_valid = 1'b1;
    count_done(4, pulses);
    pix_out_valid = 1'b0;
    check("ab_no_done", 32'(pulses), 32'h0);
    run_start(13'd4, 13'd2, 2'd1);
    check("ab_restart_valid", 32'(core_valid), 32'h1);
    check("ab_restart_index", core_loop_index, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Single core, 3x1 frame; one pixel arrives with the last handshake.
    core_ready = 2'b11;
    run_start(13'd3, 13'd1, 2'd0);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("sc_valid_%0d", i), 32'(core_valid), 32'h1);
      check($sformatf("sc_index_%0d", i), core_loop_index, 32'(i));
      pix_out_valid = (i == 3);
      tick();
    end
    tick();
    tick();
    pix_out_valid = 1'b0;
    count_done(6, pulses);
    check("sc_done_pulses", 32'(pulses), 32'h1);

    // Requested 3 extra cores on a 2-core build clamps to pointer 0,1,0.
    run_start(13'd3, 13'd1, 2'd3);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("cl_valid_%0d", i), 32'(core_valid), (i == 2) ? 32'h2 : 32'h1);
      check($sformatf("cl_index_%0d", i), core_loop_index, 32'(i));
      tick();
    end
    check("cl_drain_valid", 32'(core_valid), 32'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cl_abort_busy", 32'(busy), 32'h0);

    // Zero-size configurations are rejected with a single cfg_error pulse.
    run_start(13'd0, 13'd2, 2'd1);
    check("ce_w0_err", 32'(cfg_error), 32'h1);
    check("ce_w0_busy", 32'(busy), 32'h0);
    check("ce_w0_valid", 32'(core_valid), 32'h0);
    tick();
    check("ce_w0_err_clear", 32'(cfg_error), 32'h0);
    check("ce_w0_busy2", 32'(busy), 32'h0);
    run_start(13'd5, 13'd0, 2'd1);
    check("ce_h0_err", 32'(cfg_error), 32'h1);
    check("ce_h0_busy", 32'(busy), 32'h0);

    // Reset mid-frame discards the frame with no pulse afterwards.
    tick();
    run_start(13'd4, 13'd2, 2'd1);
    tick();
    areset = 1'b1;
    #1;
    check("mr_valid", 32'(core_valid), 32'h0);
    check("mr_index", core_loop_index, 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    tick();
    areset = 1'b0;
    pix_out_valid = 1'b1;
    count_done(10, pulses);
    pix_out_valid = 1'b0;
    check("mr_no_done", 32'(pulses), 32'h0);
    check("mr_busy_after", 32'(busy), 32'h0);
    check("mr_cfgerr_after", 32'(cfg_error), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
